// File: rtl/dstack_tos_ctrl.sv
// dstack_tos_ctrl
// Data-stack front end. Keeps top-of-stack in a register, tracks live depth,
// and turns stack micro-ops into we/delta/wd commands for the RAM stack that
// holds every entry below TOS. Next-on-stack comes back on ram_rd.
// Overflowing or underflowing ops are rejected and flagged in sticky errors.
// After each op that touches the RAM, one settle cycle lets ram_rd show the
// new NOS before the next op is taken.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   op, din, op_valid    micro-op, operand, valid
//   op_ready             op can be accepted this cycle
//   clear_err            clears ovf_err / unf_err at the next edge
//   tos, nos             top / next-on-stack (nos mirrors ram_rd)
//   depth, empty, full   live entry count including TOS, and its bounds
//   ovf_err, unf_err     sticky error flags
//   ram_we, ram_delta,   command to the RAM stack, valid only in the
//   ram_wd               accept cycle; ram_wd always carries tos
//   ram_rd               current NOS from the RAM stack
module dstack_tos_ctrl #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 512,
    parameter int DW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] din,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic             clear_err,
    output logic [WIDTH-1:0] tos,
    output logic [WIDTH-1:0] nos,
    output logic [DW-1:0]    depth,
    output logic             empty,
    output logic             full,
    output logic             ovf_err,
    output logic             unf_err,
    output logic             ram_we,
    output logic [1:0]       ram_delta,
    output logic [WIDTH-1:0] ram_wd,
    input  logic [WIDTH-1:0] ram_rd
);

    localparam logic [2:0] OP_NOP     = 3'b000;
    localparam logic [2:0] OP_PUSH    = 3'b001;
    localparam logic [2:0] OP_DROP    = 3'b010;
    localparam logic [2:0] OP_DUP     = 3'b011;
    localparam logic [2:0] OP_SWAP    = 3'b100;
    localparam logic [2:0] OP_OVER    = 3'b101;
    localparam logic [2:0] OP_REPLACE = 3'b110;
    localparam logic [2:0] OP_NIP     = 3'b111;

    localparam logic [1:0] D_HOLD = 2'b00;
    localparam logic [1:0] D_INC  = 2'b01;
    localparam logic [1:0] D_DEC  = 2'b11;

    localparam logic [DW-1:0] DEPTH_C = DW'(DEPTH);
    localparam logic [DW-1:0] ZERO_C  = DW'(0);
    localparam logic [DW-1:0] ONE_C   = DW'(1);
    localparam logic [DW-1:0] TWO_C   = DW'(2);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_SETTLE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] tos_q, tos_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             accept_s;
    logic             full_s;
    logic             empty_s;
    logic             lt2_s;
    logic             we_s;
    logic [1:0]       delta_s;
    logic             ovf_set_s;
    logic             unf_set_s;

    // Decode the accepted op into a RAM command, legality and next TOS/depth.
    always_comb begin
        op_ready  = (state_q == S_IDLE);
        accept_s  = op_valid && op_ready;
        full_s    = (depth_q == DEPTH_C);
        empty_s   = (depth_q == ZERO_C);
        lt2_s     = (depth_q < TWO_C);
        we_s      = 1'b0;
        delta_s   = D_HOLD;
        tos_d     = tos_q;
        depth_d   = depth_q;
        ovf_set_s = 1'b0;
        unf_set_s = 1'b0;
        if (accept_s) begin
            case (op)
                OP_PUSH: begin
                    if (full_s) begin
                        ovf_set_s = 1'b1;
                    end else begin
                        we_s    = 1'b1;
                        delta_s = D_INC;
                        tos_d   = din;
                        depth_d = depth_q + ONE_C;
                    end
                end
                OP_DROP: begin
                    if (empty_s) begin
                        unf_set_s = 1'b1;
                    end else begin
                        delta_s = D_DEC;
                        // Dropping the last entry leaves nothing meaningful on ram_rd.
                        tos_d   = (depth_q == ONE_C) ? {WIDTH{1'b0}} : ram_rd;
                        depth_d = depth_q - ONE_C;
                    end
                end
                OP_DUP: begin
                    if (full_s) begin
                        ovf_set_s = 1'b1;
                    end else if (empty_s) begin
                        unf_set_s = 1'b1;
                    end else begin
                        we_s    = 1'b1;
                        delta_s = D_INC;
                        depth_d = depth_q + ONE_C;
                    end
                end
                OP_SWAP: begin
                    if (lt2_s) begin
                        unf_set_s = 1'b1;
                    end else begin
                        // Old TOS overwrites NOS in place while NOS moves into TOS.
                        we_s  = 1'b1;
                        tos_d = ram_rd;
                    end
                end
                OP_OVER: begin
                    // Overflow is checked first so it wins over underflow.
                    if (full_s) begin
                        ovf_set_s = 1'b1;
                    end else if (lt2_s) begin
                        unf_set_s = 1'b1;
                    end else begin
                        we_s    = 1'b1;
                        delta_s = D_INC;
                        tos_d   = ram_rd;
                        depth_d = depth_q + ONE_C;
                    end
                end
                OP_REPLACE: begin
                    tos_d   = din;
                    depth_d = empty_s ? ONE_C : depth_q;
                end
                OP_NIP: begin
                    if (lt2_s) begin
                        unf_set_s = 1'b1;
                    end else begin
                        delta_s = D_DEC;
                        depth_d = depth_q - ONE_C;
                    end
                end
                OP_NOP: begin
                end
                default: begin
                end
            endcase
        end else begin
            we_s = 1'b0;
        end
        // A newly detected error beats a simultaneous clear.
        ovf_d = (ovf_q && !clear_err) || ovf_set_s;
        unf_d = (unf_q && !clear_err) || unf_set_s;
    end

    // Next FSM state: any RAM command needs one cycle for ram_rd to settle.
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE: begin
                if (we_s || (delta_s != D_HOLD)) begin
                    state_d = S_SETTLE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETTLE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State, TOS, depth and error flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            tos_q   <= {WIDTH{1'b0}};
            depth_q <= ZERO_C;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tos_q   <= tos_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign tos       = tos_q;
    assign nos       = ram_rd;
    assign depth     = depth_q;
    assign empty     = empty_s;
    assign full      = full_s;
    assign ovf_err   = ovf_q;
    assign unf_err   = unf_q;
    assign ram_we    = we_s;
    assign ram_delta = delta_s;
    assign ram_wd    = tos_q;

endmodule

// File: doc/dstack_tos_ctrl.md
Name: dstack_tos_ctrl

Overview:
Data-stack front end for the microForth core. It holds top-of-stack (TOS) in a register and tracks stack depth. It decodes stack micro-ops from the execute stage into `we` / `delta` / `wd` commands for the RAM_stack block directly downstream, and receives next-on-stack (NOS) back on that block's `rd`. It rejects overflowing and underflowing ops, records them in sticky error flags, and inserts a one-cycle settle wait after every RAM-touching op so that NOS is valid before the next op.

Parameters:
- WIDTH, 16, data word width; must match RAM_stack WIDTH.
- DEPTH, 512, RAM_stack DEPTH; maximum stack depth including TOS is DEPTH (RAM slot 0 is never occupied).
- DW, $clog2(DEPTH)+1, width of the depth counter.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- op  in  3  micro-op: 000 NOP, 001 PUSH, 010 DROP, 011 DUP, 100 SWAP, 101 OVER, 110 REPLACE, 111 NIP.
- din  in  WIDTH  operand for PUSH and REPLACE.
- op_valid  in  1  op/din valid.
- op_ready  out  1  block can accept an op this cycle.
- clear_err  in  1  clears ovf_err and unf_err.
- tos  out  WIDTH  current TOS, registered.
- nos  out  WIDTH  equal to ram_rd; meaningful only when depth>=2 and op_ready=1.
- depth  out  DW  number of live entries including TOS.
- empty  out  1  depth==0.
- full  out  1  depth==DEPTH.
- ovf_err  out  1  sticky overflow flag.
- unf_err  out  1  sticky underflow flag.
- ram_we  out  1  to RAM_stack `we`.
- ram_delta  out  2  to RAM_stack `delta`: 01 = +1, 11 = -1, 00 = hold.
- ram_wd  out  WIDTH  to RAM_stack `wd`; always equals tos.
- ram_rd  in  WIDTH  from RAM_stack `rd` (current NOS).

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - tos=0, depth=0, ovf_err=0, unf_err=0, state IDLE, op_ready=1.
  - ram_we=0, ram_delta=00.
- Accept: an op is accepted when op_valid && op_ready.
- RAM command outputs:
  - Combinational from the accepted op, asserted in the accept cycle only.
  - At all other times ram_we=0 and ram_delta=00.
- Per accepted legal op (RAM command, then TOS / depth update at the next edge):
  - PUSH: we=1, delta=01; tos<=din; depth+1.
  - DROP: delta=11; tos<=(depth==1 ? 0 : ram_rd); depth-1.
  - DUP: we=1, delta=01; tos unchanged; depth+1.
  - SWAP: we=1, delta=00 (overwrites NOS with old TOS); tos<=ram_rd; depth unchanged.
  - OVER: we=1, delta=01; tos<=ram_rd; depth+1.
  - NIP: delta=11, we=0; tos unchanged; depth-1.
  - REPLACE: no RAM command; tos<=din.
  - NOP: no effect.
- Legality (illegal ops are rejected: no RAM command, no tos/depth change, still consume the handshake):
  - PUSH, DUP, OVER when full → set ovf_err.
  - DROP, DUP when depth==0 → set unf_err.
  - SWAP, OVER, NIP when depth<2 → set unf_err.
  - REPLACE on empty is legal: tos<=din, depth becomes 1.
  - OVER is checked for both conditions; overflow has priority over underflow.
- Error flags:
  - Sticky.
  - clear_err clears both flags at the next edge.
  - If clear_err coincides with a new error in the same cycle, set wins.
- FSM: IDLE, SETTLE.
  - IDLE: op_ready=1. A legal accepted op that drove ram_we or a non-zero ram_delta moves to SETTLE. All other ops stay in IDLE.
  - SETTLE: op_ready=0 for exactly one cycle, during which ram_rd updates to the new NOS; then return to IDLE.
  - Throughput: one RAM-touching op per 2 cycles; REPLACE, NOP and rejected ops run 1 per cycle.
- depth arithmetic is unsigned DW bits and never wraps: bounds are enforced by the legality rules.
- Reset mid-operation: reset asserted in SETTLE returns to IDLE with depth=0. RAM_stack pointers are not reset; the depth counter is authoritative, and the controller issues no pop while depth==0.
- op_valid held with op_ready=0: the op is held by the producer, not lost, and is accepted in the next IDLE cycle.

Test Plan:
1. Reset, then PUSH 0x1111, PUSH 0x2222 → tos=0x2222, depth=2, nos=0x1111; op_ready low one cycle after each push; ram_delta=01 and ram_we=1 in each accept cycle.
2. From (1): SWAP → tos=0x1111, nos=0x2222, depth=2, ram_delta=00, ram_we=1. Then OVER → tos=0x2222, depth=3.
3. DROP on depth=1 with tos=0x00AB → tos=0, depth=0, empty=1. Second DROP → rejected, unf_err=1, ram_delta=00, depth stays 0.
4. Fill to depth=DEPTH (512) with PUSHes → full=1. Further PUSH → ovf_err=1, tos and depth unchanged. clear_err → both flags 0 next cycle.
5. Back-to-back: hold op_valid with PUSH, REPLACE 0x5A5A, NIP → accepts at cycles 0, 2, 3; final tos=0x5A5A, depth decremented by NIP, op_ready=1 during the cycle-2 REPLACE.
6. Assert rst during SETTLE after a PUSH → immediately tos=0, depth=0, op_ready=1, ram_we=0, ram_delta=00; a DROP then sets unf_err.
